// File: rtl/seg7_scan_driver.sv
// Multiplexed NDIG-digit 7-segment driver: programmable scan prescaler,
// double-buffered hex value, decimal points, leading-zero blanking, selectable polarity.
module seg7_scan_driver #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              load,
    input  logic              blank_lz,
    output logic [6:0]        seg_out,
    output logic              dp_out,
    output logic [NDIG-1:0]   an_out,
    output logic              frame_done
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned VAL_W = 4 * NDIG;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    // Inactive levels for the pins, used at reset
    localparam logic [6:0]      SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic            DP_OFF  = ACTIVE_LOW;
    localparam logic [NDIG-1:0] AN_OFF  = {NDIG{ACTIVE_LOW}};

    // Active-high a..g segment code for one hex nibble
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h7E;
            4'h1:    code = 7'h30;
            4'h2:    code = 7'h6D;
            4'h3:    code = 7'h79;
            4'h4:    code = 7'h33;
            4'h5:    code = 7'h5B;
            4'h6:    code = 7'h5F;
            4'h7:    code = 7'h70;
            4'h8:    code = 7'h7F;
            4'h9:    code = 7'h7B;
            4'hA:    code = 7'h77;
            4'hB:    code = 7'h1F;
            4'hC:    code = 7'h4E;
            4'hD:    code = 7'h3D;
            4'hE:    code = 7'h4F;
            default: code = 7'h47;
        endcase
        return code;
    endfunction

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [IDX_W-1:0] idx_q,        idx_d;
    logic [VAL_W-1:0] shadow_val_q, shadow_val_d;
    logic [NDIG-1:0]  shadow_dp_q,  shadow_dp_d;
    logic [VAL_W-1:0] pend_val_q,   pend_val_d;
    logic [NDIG-1:0]  pend_dp_q,    pend_dp_d;
    logic             pend_valid_q, pend_valid_d;
    logic [6:0]       seg_q,        seg_d;
    logic             dp_q,         dp_d;
    logic [NDIG-1:0]  an_q,         an_d;
    logic             frame_done_q, frame_done_d;

    logic             tick_c;
    logic             last_c;
    logic [3:0]       cur_nib_c;
    logic             cur_dp_c;
    logic             cur_zero_c;
    logic             zero_above_c;
    logic             blank_c;
    logic [6:0]       seg_raw_c;
    logic [NDIG-1:0]  an_raw_c;

    // Digit selection and blanking: zero_above tracks "this nibble and all higher are 0"
    always_comb begin
        cur_nib_c    = 4'h0;
        cur_dp_c     = 1'b0;
        cur_zero_c   = 1'b0;
        zero_above_c = 1'b1;
        for (int j = int'(NDIG) - 1; j >= 0; j--) begin
            zero_above_c = zero_above_c && (shadow_val_q[4*j +: 4] == 4'h0);
            if (IDX_W'(j) == idx_q) begin
                cur_nib_c  = shadow_val_q[4*j +: 4];
                cur_dp_c   = shadow_dp_q[j];
                cur_zero_c = zero_above_c;
            end
        end
        blank_c   = blank_lz && (idx_q != '0) && cur_zero_c;
        seg_raw_c = blank_c ? 7'h00 : hex_decode(cur_nib_c);
        an_raw_c  = NDIG'(1) << idx_q;
    end

    // Next-state: prescaler, scan index, drive registers, double buffer
    always_comb begin
        tick_c       = (cnt_q == CNT_MAX);
        last_c       = (idx_q == IDX_LAST);

        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        an_d         = an_q;
        frame_done_d = 1'b0;

        if (tick_c) begin
            cnt_d        = '0;
            seg_d        = seg_raw_c ^ {7{ACTIVE_LOW}};
            dp_d         = cur_dp_c ^ ACTIVE_LOW;
            an_d         = an_raw_c ^ {NDIG{ACTIVE_LOW}};
            frame_done_d = last_c;
            idx_d        = last_c ? '0 : idx_q + IDX_W'(1);
            // Commit after the last digit was computed from the old shadow
            if (last_c && pend_valid_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
                pend_valid_d = 1'b0;
            end
        end

        // A load in the commit cycle lands in pending for the following frame
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized scoreboard bench for seg7_scan_driver: three configurations share one
// stimulus stream; a digit-level reference model predicts every cycle's pin state.
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [7:0] an;
        logic       fd;
    } obs_t;

    localparam int NI = 3;
    int nd  [NI] = '{4, 4, 1};
    int div [NI] = '{4, 1, 3};
    bit al  [NI] = '{1'b1, 1'b0, 1'b1};

    logic [6:0] dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        blank_lz;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [6:0] a_seg, b_seg, c_seg;
    logic       a_dp,  b_dp,  c_dp;
    logic [3:0] a_an,  b_an;
    logic [0:0] c_an;
    logic       a_fd,  b_fd,  c_fd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NDIG(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_a (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg_out(a_seg), .dp_out(a_dp), .an_out(a_an),
        .frame_done(a_fd));

    seg7_scan_driver #(.NDIG(4), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) u_b (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg_out(b_seg), .dp_out(b_dp), .an_out(b_an),
        .frame_done(b_fd));

    seg7_scan_driver #(.NDIG(1), .SCAN_DIV(3), .ACTIVE_LOW(1'b1)) u_c (
        .clk(clk), .rst(rst), .value(value[3:0]), .dp_in(dp_in[0:0]), .load(load),
        .blank_lz(blank_lz), .seg_out(c_seg), .dp_out(c_dp), .an_out(c_an),
        .frame_done(c_fd));

    // ---------------- reference model ----------------
    int         cnt  [NI];
    int         idx  [NI];
    logic [3:0] sh   [NI][8];
    logic [3:0] pn   [NI][8];
    logic [7:0] shdp [NI];
    logic [7:0] pndp [NI];
    bit         pv   [NI];
    obs_t       held [NI];
    obs_t       q_a[$], q_b[$], q_c[$];

    function automatic logic [7:0] an_mask(int k);
        return 8'((1 << nd[k]) - 1);
    endfunction

    function automatic obs_t idle_obs(int k);
        obs_t o;
        o.seg = al[k] ? 7'h7F : 7'h00;
        o.dp  = al[k];
        o.an  = al[k] ? an_mask(k) : 8'h00;
        o.fd  = 1'b0;
        return o;
    endfunction

    // Pin state while digit d is shown; digits above the most significant nonzero one blank
    function automatic obs_t digit_obs(int k, int d, bit blz);
        obs_t o;
        int   msd;
        msd = 0;
        for (int j = 0; j < nd[k]; j++)
            if (sh[k][j] != 4'h0) msd = j;
        o.seg = (blz && d > msd) ? 7'h00 : dec_tab[sh[k][d]];
        o.dp  = shdp[k][d];
        o.an  = 8'(1 << d);
        o.fd  = (d == nd[k] - 1);
        if (al[k]) begin
            o.seg = ~o.seg;
            o.dp  = ~o.dp;
            o.an  = ~o.an & an_mask(k);
        end
        return o;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                cnt[k] = 0;
                idx[k] = 0;
                pv[k]  = 1'b0;
                shdp[k] = 8'h00;
                pndp[k] = 8'h00;
                for (int j = 0; j < 8; j++) begin
                    sh[k][j] = 4'h0;
                    pn[k][j] = 4'h0;
                end
                held[k] = idle_obs(k);
            end else begin
                held[k].fd = 1'b0;
                if (cnt[k] == div[k] - 1) begin
                    held[k] = digit_obs(k, idx[k], blank_lz);
                    if (idx[k] == nd[k] - 1 && pv[k]) begin
                        for (int j = 0; j < 8; j++) sh[k][j] = pn[k][j];
                        shdp[k] = pndp[k];
                        pv[k]   = 1'b0;
                    end
                    idx[k] = (idx[k] + 1) % nd[k];
                    cnt[k] = 0;
                end else begin
                    cnt[k] = cnt[k] + 1;
                end
                if (load) begin
                    for (int j = 0; j < nd[k]; j++) pn[k][j] = value[4*j +: 4];
                    pndp[k] = 8'(dp_in) & an_mask(k);
                    pv[k]   = 1'b1;
                end
            end
            case (k)
                0:       q_a.push_back(held[k]);
                1:       q_b.push_back(held[k]);
                default: q_c.push_back(held[k]);
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got seg=%h dp=%b an=%h fd=%b, expected seg=%h dp=%b an=%h fd=%b (t=%0t)",
                     name, act.seg, act.dp, act.an, act.fd, exp.seg, exp.dp, exp.an, exp.fd, $time);
        end
    endtask

    task automatic missing(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no expected entry queued (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (q_a.size() == 0) missing("scan_a");
        else begin
            e = q_a.pop_front();
            check_obs("scan_a", obs_t'({a_seg, a_dp, 4'h0, a_an, a_fd}), e);
        end
        if (q_b.size() == 0) missing("scan_b");
        else begin
            e = q_b.pop_front();
            check_obs("scan_b", obs_t'({b_seg, b_dp, 4'h0, b_an, b_fd}), e);
        end
        if (q_c.size() == 0) missing("scan_c");
        else begin
            e = q_c.pop_front();
            check_obs("scan_c", obs_t'({c_seg, c_dp, 7'h00, c_an, c_fd}), e);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] want);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (a_an == want) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_an: anode pattern %h never seen", want);
        end
    endtask

    task automatic wait_frame_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (a_fd) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_frame_done: frame_done never pulsed");
        end
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // After rst is released: three idle cycles, then digit 0 lit showing "0"
    task automatic check_restart();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("restart_an_idle", 32'(a_an), 32'h0F);
        end
        step();
        check("restart_an_digit0", 32'(a_an), 32'h0E);
        check("restart_seg_zero", 32'(a_seg), 32'h01);
        check("restart_dp", 32'(a_dp), 32'h1);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        blank_lz = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;

        step();
        check("reset_seg_al", 32'(a_seg), 32'h7F);
        check("reset_an_al", 32'(a_an), 32'h0F);
        check("reset_dp_al", 32'(a_dp), 32'h1);
        check("reset_fd", 32'(a_fd), 32'h0);
        check("reset_seg_ah", 32'(b_seg), 32'h00);
        check("reset_an_ah", 32'(b_an), 32'h00);
        step();
        step();
        check_restart();
        repeat (20) step();

        load_word(16'h12AF, 4'b0100);
        repeat (40) step();
        wait_an(4'hE); check("d0_F", 32'(a_seg), 32'h38);
        wait_an(4'hD); check("d1_A", 32'(a_seg), 32'h08);
        wait_an(4'hB); check("d2_2", 32'(a_seg), 32'h12);
                       check("d2_dp", 32'(a_dp), 32'h0);
        wait_an(4'h7); check("d3_1", 32'(a_seg), 32'h4F);
                       check("d3_frame_done", 32'(a_fd), 32'h1);

        blank_lz = 1'b1;
        load_word(16'h0050, 4'b0000);
        repeat (40) step();
        wait_an(4'h7); check("lz_d3_blank", 32'(a_seg), 32'h7F);
        wait_an(4'hB); check("lz_d2_blank", 32'(a_seg), 32'h7F);
        wait_an(4'hD); check("lz_d1_5", 32'(a_seg), 32'h24);
        wait_an(4'hE); check("lz_d0_0", 32'(a_seg), 32'h01);
        load_word(16'h0000, 4'b0000);
        repeat (40) step();
        wait_an(4'hD); check("lz_zero_d1_blank", 32'(a_seg), 32'h7F);
        wait_an(4'hE); check("lz_zero_d0", 32'(a_seg), 32'h01);

        blank_lz = 1'b0;
        wait_an(4'hD);
        load_word(16'h1111, 4'b0000);
        wait_an(4'hB); check("tear_d2_old", 32'(a_seg), 32'h01);
        wait_an(4'h7); check("tear_d3_old", 32'(a_seg), 32'h01);
        wait_an(4'hE); check("tear_d0_new", 32'(a_seg), 32'h4F);
        wait_frame_done();
        repeat (15) step();
        load_word(16'h2222, 4'b0000);
        wait_an(4'hE); check("commit_load_still_1", 32'(a_seg), 32'h4F);
        wait_an(4'h7); check("commit_load_d3_1", 32'(a_seg), 32'h4F);
        wait_an(4'hE); check("commit_load_now_2", 32'(a_seg), 32'h12);

        wait_an(4'hB);
        rst = 1'b1;
        step();
        check("midscan_rst_seg", 32'(a_seg), 32'h7F);
        check("midscan_rst_an", 32'(a_an), 32'h0F);
        check("midscan_rst_fd", 32'(a_fd), 32'h0);
        check_restart();

        for (int i = 0; i < 500; i++) begin
            load  = ($urandom_range(0, 5) == 0);
            value = 16'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
            rst   = ($urandom_range(0, 96) == 0);
            step();
        end
        load = 1'b0;
        rst  = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
